// File: rtl/axis_rx_pkg.sv
// Shared constants for the AXI-Stream receive checker: FSM encoding, LFSR seed/taps
// and the saturating-increment helper used by every counter.
package axis_rx_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form over q[15:0]
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v == max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/axis_rx_lfsr.sv
// 16-bit maximal-length LFSR that paces tready when AXIS_RX_THROTTLE_EN is defined.
module axis_rx_lfsr
    import axis_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] r_q;
    logic        w_fb;

    assign w_fb = ^(r_q & LFSR_TAPS);
    assign q    = r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= LFSR_SEED;
        end else if (en) begin
            r_q <= {r_q[14:0], w_fb};
        end
    end

endmodule

// File: rtl/axis_rx_checker.sv
// AXI-Stream MM2S sink: checks an incrementing word pattern, full tkeep and tlast placement.
// Define AXIS_RX_THROTTLE_EN to gate tready with an LFSR for backpressure testing.
module axis_rx_checker
    import axis_rx_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                PKT_LEN   = 256,
    parameter int                PKT_NUM   = 4,
    parameter logic [DATA_W-1:0] DATA_SEED = '0,
    parameter int                TMO_CYC   = 65535,
    parameter int                CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                gpio_start,
    input  logic [DATA_W-1:0]   M_AXIS_tdata,
    input  logic [DATA_W/8-1:0] M_AXIS_tkeep,
    input  logic                M_AXIS_tlast,
    input  logic                M_AXIS_tvalid,
    output logic                M_AXIS_tready,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                timeout,
    output logic [CNT_W-1:0]    err_data_cnt,
    output logic [CNT_W-1:0]    err_keep_cnt,
    output logic [CNT_W-1:0]    err_len_cnt,
    output logic [CNT_W-1:0]    pkt_cnt,
    output logic [DATA_W-1:0]   first_bad_data
);

    localparam int          IDLE_W  = $clog2(TMO_CYC + 1);
    localparam logic [31:0] CNT_MAX = 32'({CNT_W{1'b1}});

    function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] v);
        return CNT_W'(sat_inc(32'(v), CNT_MAX));
    endfunction

    logic [1:0]        r_state;
    logic              r_gpio_d;
    logic              r_tready;
    logic              r_timeout;
    logic [DATA_W-1:0] r_exp;
    logic [15:0]       r_beat;
    logic [IDLE_W-1:0] r_idle;
    logic [CNT_W-1:0]  r_err_data;
    logic [CNT_W-1:0]  r_err_keep;
    logic [CNT_W-1:0]  r_err_len;
    logic [CNT_W-1:0]  r_pkt;
    logic [DATA_W-1:0] r_first_bad;

    logic              w_rise;
    logic              w_start;
    logic              w_hs;
    logic              w_tmo;
    logic              w_data_err;
    logic              w_keep_err;
    logic              w_len_err;
    logic [CNT_W-1:0]  w_pkt_next;
    logic [1:0]        w_next_state;
    logic              w_ready_gate;

`ifdef AXIS_RX_THROTTLE_EN
    logic [15:0] w_lfsr;

    axis_rx_lfsr u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .q   (w_lfsr)
    );

    assign w_ready_gate = w_lfsr[0] | w_lfsr[1];
`else
    assign w_ready_gate = 1'b1;
`endif

    assign w_rise     = gpio_start & ~r_gpio_d;
    assign w_start    = w_rise && (r_state != ST_RUN);
    assign w_hs       = M_AXIS_tvalid & r_tready;
    assign w_tmo      = (r_state == ST_RUN) && !w_hs && (r_idle == IDLE_W'(TMO_CYC - 1));
    assign w_data_err = (M_AXIS_tdata != r_exp);
    assign w_keep_err = (M_AXIS_tkeep != '1);
    // Early tlast and missing tlast are both "tlast disagrees with the last-beat position"
    assign w_len_err  = M_AXIS_tlast ^ (r_beat == 16'(PKT_LEN - 1));
    assign w_pkt_next = inc_cnt(r_pkt);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (w_rise) w_next_state = ST_RUN;
            ST_RUN: begin
                if ((w_hs && M_AXIS_tlast && (w_pkt_next == CNT_W'(PKT_NUM))) || w_tmo)
                    w_next_state = ST_DONE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_gpio_d    <= 1'b0;
            r_tready    <= 1'b0;
            r_timeout   <= 1'b0;
            r_beat      <= '0;
            r_idle      <= '0;
            r_err_data  <= '0;
            r_err_keep  <= '0;
            r_err_len   <= '0;
            r_pkt       <= '0;
            r_first_bad <= '0;
        end else begin
            r_gpio_d <= gpio_start;
            r_state  <= w_next_state;
            // Registered so the DMA never sees a combinational path into tready
            r_tready <= (w_next_state == ST_RUN) && w_ready_gate;
            if (w_start) begin
                r_timeout   <= 1'b0;
                r_exp       <= DATA_SEED;
                r_beat      <= '0;
                r_idle      <= '0;
                r_err_data  <= '0;
                r_err_keep  <= '0;
                r_err_len   <= '0;
                r_pkt       <= '0;
                r_first_bad <= '0;
            end else if (r_state == ST_RUN) begin
                if (w_hs) begin
                    r_idle <= '0;
                    r_exp  <= r_exp + DATA_W'(1);
                    if (w_data_err) begin
                        r_err_data <= inc_cnt(r_err_data);
                        if (r_err_data == '0) r_first_bad <= M_AXIS_tdata;
                    end
                    if (w_keep_err) r_err_keep <= inc_cnt(r_err_keep);
                    if (w_len_err)  r_err_len  <= inc_cnt(r_err_len);
                    if (M_AXIS_tlast) begin
                        r_pkt  <= w_pkt_next;
                        r_beat <= '0;
                    end else begin
                        r_beat <= 16'(sat_inc(32'(r_beat), 32'hFFFF));
                    end
                end else if (w_tmo) begin
                    r_timeout <= 1'b1;
                end else begin
                    r_idle <= r_idle + IDLE_W'(1);
                end
            end
        end
    end

    assign M_AXIS_tready  = r_tready;
    assign busy           = (r_state == ST_RUN);
    assign done           = (r_state == ST_DONE);
    assign timeout        = r_timeout;
    assign pass           = done && !r_timeout && (r_err_data == '0) &&
                            (r_err_keep == '0) && (r_err_len == '0);
    assign err_data_cnt   = r_err_data;
    assign err_keep_cnt   = r_err_keep;
    assign err_len_cnt    = r_err_len;
    assign pkt_cnt        = r_pkt;
    assign first_bad_data = r_first_bad;

endmodule
